// File: rtl/seq_detector_param.sv
// seq_detector_param: masked serial pattern detector with overlap select, match pulse and saturating count
module seq_detector_param #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          ser_in,
  input  logic          in_valid,
  input  logic [W-1:0]  pattern,
  input  logic [W-1:0]  mask,
  input  logic          overlap,
  input  logic          clr,
  output logic          found,
  output logic [CW-1:0] match_count,
  output logic          saturated
);
  localparam int FW = $clog2(W + 1);
  localparam logic [FW-1:0] FULL = FW'(W);
  logic [W-1:0]  hist_q, hist_d, hist_n;
  logic [FW-1:0] fill_q, fill_d, fill_n;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          found_q, found_d, sat_q, sat_d, acc, hit;
  always_comb begin
    acc     = in_valid & ~clr;
    hist_n  = {hist_q[W-2:0], ser_in};
    fill_n  = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    hit     = acc && (fill_n == FULL) && (((hist_n ^ pattern) & mask) == '0);
    hist_d  = clr ? '0 : acc ? hist_n : hist_q;
    fill_d  = clr ? '0 : !acc ? fill_q : (hit && !overlap) ? '0 : fill_n;
    cnt_d   = clr ? '0 : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    sat_d   = clr ? 1'b0 : sat_q | (cnt_d == '1);
    found_d = hit;
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      found_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      found_q <= found_d;
    end
  end
  assign found       = found_q;
  assign match_count = cnt_q;
  assign saturated   = sat_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table-driven and randomized model-checked bench for seq_detector_param
module tb_seq_detector_param;
  localparam int W = 4;
  logic clock = 1'b0, rst_n = 1'b0, ser_in = 1'b0, in_valid = 1'b0, overlap = 1'b1, clr = 1'b0;
  logic [W-1:0] pattern = '0, mask = '1;
  logic found8, found2, sat8, sat2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  int checks = 0, errors = 0;
  seq_detector_param #(.W(W), .CW(8)) u8 (
    .clock(clock), .rst_n(rst_n), .ser_in(ser_in), .in_valid(in_valid), .pattern(pattern),
    .mask(mask), .overlap(overlap), .clr(clr), .found(found8), .match_count(cnt8), .saturated(sat8)
  );
  seq_detector_param #(.W(W), .CW(2)) u2 (
    .clock(clock), .rst_n(rst_n), .ser_in(ser_in), .in_valid(in_valid), .pattern(pattern),
    .mask(mask), .overlap(overlap), .clr(clr), .found(found2), .match_count(cnt2), .saturated(sat2)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic c, v, b, f;
    int   c8, c2;
    logic s2;
  } vec_t;
  vec_t tv[$];
  bit   m_bits[$];
  int   m_start, m_c8, m_c2;
  bit   m_s8, m_s2, m_f;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic void add(input logic c, v, b, f, input int c8, c2, input logic s2);
    vec_t r;
    r.c = c; r.v = v; r.b = b; r.f = f; r.c8 = c8; r.c2 = c2; r.s2 = s2;
    tv.push_back(r);
  endfunction
  function automatic void m_reset();
    m_bits.delete();
    m_start = 0; m_c8 = 0; m_c2 = 0; m_s8 = 0; m_s2 = 0; m_f = 0;
  endfunction
  function automatic void m_step();
    bit ok;
    int n;
    m_f = 0;
    if (clr) begin
      m_reset();
      return;
    end
    if (!in_valid) return;
    m_bits.push_back(ser_in);
    n = m_bits.size();
    if (n - m_start < W) return;
    ok = 1;
    for (int i = 0; i < W; i++)
      if (mask[i] && m_bits[n-1-i] != pattern[i]) ok = 0;
    if (!ok) return;
    m_f  = 1;
    m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
    m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
    m_s8 = m_s8 | (m_c8 == 255);
    m_s2 = m_s2 | (m_c2 == 3);
    if (!overlap) m_start = n;
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    in_valid = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_reset();
  endtask
  task automatic run_tab(input string nm);
    foreach (tv[i]) begin
      clr = tv[i].c; in_valid = tv[i].v; ser_in = tv[i].b;
      tick();
      chk({nm, " found"}, found8, tv[i].f);
      chk({nm, " cnt8"}, cnt8, tv[i].c8);
      chk({nm, " cnt2"}, cnt2, tv[i].c2);
      chk({nm, " sat2"}, sat2, tv[i].s2);
    end
    tv.delete();
    clr = 1'b0; in_valid = 1'b0;
  endtask
  initial begin
    #2;
    chk("reset found", found8, 0);
    chk("reset cnt8", cnt8, 0);
    chk("reset sat8", sat8, 0);
    pattern = 4'b1011; mask = 4'b1111; overlap = 1'b1;
    do_reset();
    add(0,1,1,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,1,0,0,0,0); add(0,1,1,1,1,1,0);
    add(0,1,0,0,1,1,0); add(0,1,1,0,1,1,0); add(0,1,1,1,2,2,0);
    run_tab("ovl_1011");
    overlap = 1'b0;
    do_reset();
    add(0,1,1,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,1,0,0,0,0); add(0,1,1,1,1,1,0);
    add(0,1,0,0,1,1,0); add(0,1,1,0,1,1,0); add(0,1,1,0,1,1,0);
    run_tab("novl_1011");
    pattern = 4'b1111; overlap = 1'b1;
    do_reset();
    add(0,1,1,0,0,0,0); add(0,1,1,0,0,0,0); add(0,1,1,0,0,0,0); add(0,1,1,1,1,1,0);
    add(0,1,1,1,2,2,0); add(0,1,1,1,3,3,1); add(0,1,1,1,4,3,1); add(0,1,1,1,5,3,1);
    run_tab("ovl_1111");
    overlap = 1'b0;
    do_reset();
    add(0,1,1,0,0,0,0); add(0,1,1,0,0,0,0); add(0,1,1,0,0,0,0); add(0,1,1,1,1,1,0);
    add(0,1,1,0,1,1,0); add(0,1,1,0,1,1,0); add(0,1,1,0,1,1,0); add(0,1,1,1,2,2,0);
    run_tab("novl_1111");
    pattern = 4'b1011; mask = 4'b1001;
    do_reset();
    add(0,1,1,0,0,0,0); add(0,1,1,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,1,1,1,1,0);
    run_tab("mask_hit");
    do_reset();
    add(0,1,0,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,1,0,0,0,0);
    run_tab("mask_miss");
    do_reset();
    add(0,1,1,0,0,0,0); add(0,0,0,0,0,0,0); add(0,1,0,0,0,0,0); add(0,0,1,0,0,0,0);
    add(0,0,1,0,0,0,0); add(0,1,1,0,0,0,0); add(0,0,0,0,0,0,0); add(0,1,1,1,1,1,0);
    add(0,0,1,0,1,1,0); add(0,0,1,0,1,1,0);
    run_tab("gaps");
    pattern = 4'b0000; mask = 4'b1111; overlap = 1'b1;
    do_reset();
    add(0,1,0,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,0,1,1,1,0);
    add(0,1,0,1,2,2,0); add(0,1,0,1,3,3,1); add(0,1,0,1,4,3,1); add(0,1,0,1,5,3,1);
    add(0,1,0,1,6,3,1); add(0,1,0,1,7,3,1);
    add(1,1,0,0,0,0,0);
    add(0,1,0,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,0,1,1,1,0);
    run_tab("sat_clr");
    chk("sat8 not set", sat8, 0);
    pattern = 4'b1011; mask = 4'b1111; overlap = 1'b1;
    do_reset();
    add(0,1,1,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,1,0,0,0,0);
    run_tab("pre_rst");
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    add(0,1,1,0,0,0,0); add(0,1,0,0,0,0,0); add(0,1,1,0,0,0,0); add(0,1,1,1,1,1,0);
    run_tab("post_rst");
    rst_n = 1'b0;
    #1;
    chk("async rst found", found8, 0);
    chk("async rst cnt8", cnt8, 0);
    #1;
    rst_n = 1'b1;
    m_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) pattern = W'($urandom);
      if ($urandom_range(0, 9) == 0) mask = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom | $urandom);
      if ($urandom_range(0, 19) == 0) overlap = ~overlap;
      in_valid = $urandom_range(0, 3) != 0;
      ser_in = 1'($urandom);
      clr = $urandom_range(0, 59) == 0;
      m_step();
      tick();
      chk("rnd found8", found8, m_f);
      chk("rnd found2", found2, m_f);
      chk("rnd cnt8", cnt8, m_c8);
      chk("rnd cnt2", cnt2, m_c2);
      chk("rnd sat8", sat8, m_s8);
      chk("rnd sat2", sat2, m_s2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector, the successor to the fixed 4-bit non-overlapping detector.
- Pattern width is configurable.
- Per-bit don't-care mask.
- Runtime selection of overlapping or non-overlapping matching.
- Bit-valid qualifier on the serial input.
- Registered single-cycle match pulse and a saturating match counter.
- Sits behind a serial data source (UART/SPI deserialiser front end) and flags framing or sync words.

Parameters:
- W, 4, pattern length in bits (W >= 2).
- CW, 8, match counter width in bits (CW >= 1).

Ports:
- clock  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- ser_in  input  1  serial data bit; sampled only when in_valid=1.
- in_valid  input  1  qualifies ser_in; when 0 no state changes except clr.
- pattern  input  W  target sequence; pattern[W-1] is the first-received bit, pattern[0] the most recent.
- mask  input  W  per-bit compare enable; 1=compare, 0=don't care; same bit order as pattern.
- overlap  input  1  1=overlapping detection, 0=non-overlapping.
- clr  input  1  synchronous clear of history, fill counter, match counter and saturated flag.
- found  output  1  one-cycle pulse, registered.
- match_count  output  CW  number of matches since reset/clr, saturating.
- saturated  output  1  sticky; set when match_count reaches 2^CW-1.

Behaviour:
- Reset (rst_n=0, async): shift history=0, fill=0, found=0, match_count=0, saturated=0.
- History: W-bit shift register.
  - On an accepted bit (in_valid=1, clr=0), shift left and insert ser_in at bit 0.
  - hist[W-1] is therefore the oldest bit.
- Fill counter: counts accepted bits, range 0..W, saturates at W.
  - A match is legal only when the fill after the current accepted bit equals W.
  - This means no false match from reset contents; this replaces the previous reset-value trick.
- Match condition, evaluated on the next-history value (hist shifted with the current bit): ((next_hist ^ pattern) & mask) == 0, AND fill_next == W, AND accepted bit.
- Latency: the match condition is evaluated on the clock edge that accepts the completing bit. found is registered high for exactly the following cycle, then low unless another match occurs.
- Overlap=1: fill stays at W after a match. Back-to-back matches on consecutive accepted bits are possible, and found can stay high on consecutive cycles.
- Overlap=0: on a match, fill resets to 0 (history contents irrelevant). The next match requires W fresh accepted bits.
- match_count: increments by 1 on each match while below 2^CW-1. It holds at max thereafter, with saturated=1. saturated is cleared only by reset or clr.
- in_valid=0 cycles: history, fill and count hold, and found=0 on the next cycle. Gaps are transparent to pattern continuity.
- clr=1: takes priority over in_valid. History=0, fill=0, match_count=0, saturated=0, found=0 next cycle. The ser_in bit presented that cycle is discarded.
- mask all zeros: every accepted bit with fill==W matches (overlap=1), or every W-th accepted bit matches (overlap=0).
- pattern, mask and overlap are sampled combinationally each accepted bit; a change affects the next accepted bit. Bits already in history are not re-evaluated.
- Reset asserted mid-stream: all state clears immediately; detection restarts from fill=0 after release.

Test Plan:
- W=4, pattern=1011, mask=1111, overlap=1, stream 1,0,1,1,0,1,1 (in_valid=1) -> found pulses the cycle after bits 4 and 7; match_count=2.
- Same stream, overlap=0 -> found only after bit 4; match_count=1.
- pattern=1111, overlap=1, eight 1s -> 5 pulses (after bits 4–8); with overlap=0 -> 2 pulses (after bits 4 and 8).
- pattern=1011, mask=1001, stream 1,1,0,1 -> match; stream 0,0,0,1 -> no match. Then insert in_valid=0 gaps between bits of 1,0,1,1 -> still a match, and found is single-cycle.
- CW=2, overlap=1, pattern=0000, mask=1111, 10 zeros -> match_count stops at 3, saturated=1. Then clr -> count=0, saturated=0, and the next 3 zeros give no match.
- Reset pulsed after bits 1,0,1 of 1011, then stream 1 -> no match (fill=1). Reset during found=1 drops found immediately.
